scsi_byte_packer: RTL

SCSI_BYTE_PACKER -- requirements
Module: scsi_byte_packer

---
 rtl/datapath_pkg.sv | 26 ++
 rtl/scsi_byte_packer_if.sv | 44 ++++
 rtl/scsi_byte_lane.sv | 22 ++
 rtl/scsi_byte_packer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the SCSI byte packer: state encoding, length width
// and the big-endian BO-to-lane mapping.
package datapath_pkg;

  localparam int unsigned LEN_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_REQ,
    S_ACK1,
    S_ACK2,
    S_PUSH,
    S_FIN
  } state_t;

  // BO=0 is the most significant byte of the 32-bit word.
  function automatic logic [4:0] lane_lsb(input logic [1:0] bo);
    return {~bo, 3'b000};
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] bo);
    return 4'b1000 >> bo;
  endfunction

endpackage

// File: rtl/scsi_byte_packer_if.sv
// Control, SCSI-side and FIFO-side signals of the byte packer, bundled with
// a master view (the packer) and a slave view (its environment).
interface scsi_byte_packer_if;
  import datapath_pkg::*;

  logic             START;
  logic             DIR;
  logic [LEN_W-1:0] LEN;
  logic             STOP;
  logic             BUSY;
  logic             DONE;

  logic             DREQ;
  logic             DACK;
  logic             SCSI_RD;
  logic             SCSI_WR;
  logic [7:0]       SCSI_DATA_IN;
  logic [7:0]       SCSI_DATA_OUT;
  logic             SCSI_OE;
  logic [1:0]       BO;

  logic             FIFO_WR;
  logic [31:0]      FIFO_WDATA;
  logic [3:0]       FIFO_BE;
  logic             FIFO_FULL;
  logic             FIFO_RD;
  logic [31:0]      FIFO_RDATA;
  logic             FIFO_EMPTY;

  modport master (
    input  START, DIR, LEN, STOP, DREQ, SCSI_DATA_IN,
           FIFO_FULL, FIFO_RDATA, FIFO_EMPTY,
    output BUSY, DONE, DACK, SCSI_RD, SCSI_WR, SCSI_DATA_OUT, SCSI_OE, BO,
           FIFO_WR, FIFO_WDATA, FIFO_BE, FIFO_RD
  );

  modport slave (
    output START, DIR, LEN, STOP, DREQ, SCSI_DATA_IN,
           FIFO_FULL, FIFO_RDATA, FIFO_EMPTY,
    input  BUSY, DONE, DACK, SCSI_RD, SCSI_WR, SCSI_DATA_OUT, SCSI_OE, BO,
           FIFO_WR, FIFO_WDATA, FIFO_BE, FIFO_RD
  );

endinterface

// File: rtl/scsi_byte_lane.sv
// BO-indexed byte extract/insert on the 32-bit word register plus the
// matching byte-enable update.
module scsi_byte_lane
  import datapath_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [3:0]  i_be,
  input  logic [1:0]  i_bo,
  input  logic [7:0]  i_byte,
  output logic [7:0]  o_byte,
  output logic [31:0] o_word,
  output logic [3:0]  o_be
);

  always_comb begin
    o_byte = i_word[lane_lsb(i_bo) +: 8];
    o_word = i_word;
    o_word[lane_lsb(i_bo) +: 8] = i_byte;
    o_be   = i_be | lane_be(i_bo);
  end

endmodule

// File: rtl/scsi_byte_packer.sv
// Packs SCSI bytes into big-endian 32-bit FIFO words (DIR=1) or unpacks FIFO
// words into SCSI bytes (DIR=0) using a DREQ/DACK two-cycle handshake.
module scsi_byte_packer
  import datapath_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  scsi_byte_packer_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  logic             r_dir;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_dec;
  logic [1:0]       r_bo;
  logic [31:0]      r_word;
  logic [3:0]       r_be;
  logic             r_stop;
  logic             w_stop;
  logic             w_ack;
  logic             w_fifo_rd;
  logic             w_fifo_wr;
  logic [7:0]       w_rd_byte;
  logic [31:0]      w_ins_word;
  logic [3:0]       w_ins_be;

  scsi_byte_lane u_lane (
    .i_word (r_word),
    .i_be   (r_be),
    .i_bo   (r_bo),
    .i_byte (bus.SCSI_DATA_IN),
    .o_byte (w_rd_byte),
    .o_word (w_ins_word),
    .o_be   (w_ins_be)
  );

  assign w_cnt_dec = r_cnt - LEN_W'(1);
  // An abort arriving mid-handshake is parked in r_stop until the next wait state.
  assign w_stop    = bus.STOP | r_stop;

  always_comb begin
    w_next    = r_state;
    w_fifo_rd = 1'b0;
    w_fifo_wr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.START) begin
          if (bus.LEN == '0)  w_next = S_FIN;
          else if (bus.DIR)   w_next = S_WAIT_REQ;
          else                w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_stop) begin
          w_next = S_FIN;
        end else if (!bus.FIFO_EMPTY) begin
          w_fifo_rd = 1'b1;
          w_next    = S_WAIT_REQ;
        end
      end
      S_WAIT_REQ: begin
        if (w_stop)        w_next = (r_dir && (r_be != '0)) ? S_PUSH : S_FIN;
        else if (bus.DREQ) w_next = S_ACK1;
      end
      S_ACK1: w_next = S_ACK2;
      S_ACK2: begin
        if (r_dir)                  w_next = ((r_bo == 2'd3) || (w_cnt_dec == '0)) ? S_PUSH : S_WAIT_REQ;
        else if (w_cnt_dec == '0)   w_next = S_FIN;
        else if (r_bo == 2'd3)      w_next = S_FETCH;
        else                        w_next = S_WAIT_REQ;
      end
      S_PUSH: begin
        if (!bus.FIFO_FULL) begin
          w_fifo_wr = 1'b1;
          w_next    = (r_cnt == '0) ? S_FIN : S_WAIT_REQ;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_bo    <= '0;
      r_word  <= '0;
      r_be    <= '0;
      r_stop  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.START) begin
            r_dir  <= bus.DIR;
            r_cnt  <= bus.LEN;
            r_bo   <= '0;
            r_word <= '0;
            r_be   <= '0;
            r_stop <= 1'b0;
          end
        end
        S_FETCH: begin
          if (w_fifo_rd) r_word <= bus.FIFO_RDATA;
        end
        S_ACK1: begin
          if (bus.STOP) r_stop <= 1'b1;
        end
        S_ACK2: begin
          if (bus.STOP) r_stop <= 1'b1;
          r_cnt <= w_cnt_dec;
          r_bo  <= r_bo + 2'd1;
          if (r_dir) begin
            r_word <= w_ins_word;
            r_be   <= w_ins_be;
          end
        end
        S_PUSH: begin
          if (bus.STOP) r_stop <= 1'b1;
          if (w_fifo_wr) begin
            r_word <= '0;
            r_be   <= '0;
          end
        end
        S_FIN: begin
          r_bo   <= '0;
          r_stop <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign w_ack             = (r_state == S_ACK1) || (r_state == S_ACK2);
  assign bus.BUSY          = (r_state != S_IDLE);
  assign bus.DONE          = (r_state == S_FIN);
  assign bus.DACK          = w_ack;
  assign bus.SCSI_RD       = w_ack & r_dir;
  assign bus.SCSI_WR       = w_ack & ~r_dir;
  assign bus.SCSI_OE       = w_ack & ~r_dir;
  assign bus.SCSI_DATA_OUT = (w_ack && !r_dir) ? w_rd_byte : '0;
  assign bus.BO            = r_bo;
  assign bus.FIFO_RD       = w_fifo_rd;
  assign bus.FIFO_WR       = w_fifo_wr;
  assign bus.FIFO_WDATA    = w_fifo_wr ? r_word : '0;
  assign bus.FIFO_BE       = w_fifo_wr ? r_be : '0;

endmodule
